// File: rtl/comp_argmax_ctrl.sv
// Argmax sequencer: streams N_CLASS scores from the score buffer through an
// external two-input comparator, folding the running maximum back each cycle.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module comp_argmax_ctrl #(
    parameter int N_CLASS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [3:0]                  rd_addr,
    input  logic signed [`DATA_LEN-1:0] rd_data,
    output logic                        cmp_load,
    output logic [3:0]                  cmp_d1_num,
    output logic signed [`DATA_LEN-1:0] cmp_d1,
    output logic [3:0]                  cmp_d2_num,
    output logic signed [`DATA_LEN-1:0] cmp_d2,
    input  logic [3:0]                  cmp_q_num,
    input  logic signed [`DATA_LEN-1:0] cmp_q,
    output logic [3:0]                  result_num,
    output logic signed [`DATA_LEN-1:0] result_val
);

    localparam logic [3:0] LAST = 4'(N_CLASS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t     state;
    logic       issue_valid;   // rd_data of the previous read is on the bus now
    logic       issue_first;   // that read was index 0: seed the comparator
    logic [3:0] issue_idx;
    logic       last_pending;  // final compare result is on cmp_q this cycle

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= 4'd0;
            issue_valid  <= 1'b0;
            issue_first  <= 1'b0;
            issue_idx    <= 4'd0;
            last_pending <= 1'b0;
            result_num   <= 4'd0;
            result_val   <= '0;
        end else begin
            done         <= 1'b0;
            issue_valid  <= rd_en;
            issue_idx    <= rd_addr;
            issue_first  <= rd_en && (rd_addr == 4'd0);
            last_pending <= issue_valid && (issue_idx == LAST);

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        rd_en   <= 1'b1;
                        rd_addr <= 4'd0;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_addr == LAST) begin
                        rd_en   <= 1'b0;
                        rd_addr <= 4'd0;
                        state   <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 4'd1;
                    end
                end
                DRAIN: begin
                    if (last_pending) begin
                        result_num <= cmp_q_num;
                        result_val <= cmp_q;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Candidate on d1 and strict d1>d2 in the comparator give lowest-index-wins ties.
    always_comb begin
        cmp_load   = issue_valid;
        cmp_d1     = '0;
        cmp_d1_num = 4'd0;
        cmp_d2     = '0;
        cmp_d2_num = 4'd0;
        if (issue_valid) begin
            cmp_d1     = rd_data;
            cmp_d1_num = issue_idx;
            if (issue_first) begin
                cmp_d2     = rd_data;
                cmp_d2_num = 4'd0;
            end else begin
                cmp_d2     = cmp_q;
                cmp_d2_num = cmp_q_num;
            end
        end
    end

endmodule

// File: tb/tb_comp_argmax_ctrl.sv
// Directed bench for comp_argmax_ctrl with a score buffer and comparator model,
// plus a second instance at N_CLASS=1.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_comp_argmax_ctrl;

    localparam int N = 10;
    typedef int vec_t [10];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- N_CLASS=10 instance ----------------
    logic start = 1'b0;
    logic busy, done, rd_en, cmp_load;
    logic [3:0] rd_addr, cmp_d1_num, cmp_d2_num, cmp_q_num, result_num;
    logic signed [`DATA_LEN-1:0] rd_data, cmp_d1, cmp_d2, cmp_q, result_val;
    logic signed [`DATA_LEN-1:0] mem [0:15];

    comp_argmax_ctrl #(.N_CLASS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cmp_load(cmp_load), .cmp_d1_num(cmp_d1_num), .cmp_d1(cmp_d1),
        .cmp_d2_num(cmp_d2_num), .cmp_d2(cmp_d2),
        .cmp_q_num(cmp_q_num), .cmp_q(cmp_q),
        .result_num(result_num), .result_val(result_val)
    );

    always_ff @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always_ff @(posedge clk) begin
        if (cmp_load) begin
            if (cmp_d1 > cmp_d2) begin
                cmp_q <= cmp_d1; cmp_q_num <= cmp_d1_num;
            end else begin
                cmp_q <= cmp_d2; cmp_q_num <= cmp_d2_num;
            end
        end
    end

    // ---------------- N_CLASS=1 instance ----------------
    logic start1 = 1'b0;
    logic busy1, done1, rd_en1, cmp_load1;
    logic [3:0] rd_addr1, cmp_d1_num1, cmp_d2_num1, cmp_q_num1, result_num1;
    logic signed [`DATA_LEN-1:0] rd_data1, cmp_d11, cmp_d21, cmp_q1, result_val1;
    logic signed [`DATA_LEN-1:0] mem1;

    comp_argmax_ctrl #(.N_CLASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .cmp_load(cmp_load1), .cmp_d1_num(cmp_d1_num1), .cmp_d1(cmp_d11),
        .cmp_d2_num(cmp_d2_num1), .cmp_d2(cmp_d21),
        .cmp_q_num(cmp_q_num1), .cmp_q(cmp_q1),
        .result_num(result_num1), .result_val(result_val1)
    );

    always_ff @(posedge clk) if (rd_en1) rd_data1 <= mem1;

    always_ff @(posedge clk) begin
        if (cmp_load1) begin
            if (cmp_d11 > cmp_d21) begin
                cmp_q1 <= cmp_d11; cmp_q_num1 <= cmp_d1_num1;
            end else begin
                cmp_q1 <= cmp_d21; cmp_q_num1 <= cmp_d2_num1;
            end
        end
    end

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) mem[i] = v[i];
    endtask

    // Called #1 after a posedge; that cycle is cycle 0. mode: 0 pulse, 1 hold, 2 re-pulse at 5.
    task automatic scan(input string name, input int mode, input bit chain,
                        input bit pre_started, input int exp_num, input int exp_val);
        int kmax;
        kmax = chain ? N + 3 : N + 4;
        if (!pre_started) start = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            chk({name, ".rd_en"}, int'(rd_en), int'(k <= N));
            if (k <= N) chk({name, ".rd_addr"}, int'(rd_addr), k - 1);
            chk({name, ".cmp_load"}, int'(cmp_load), int'(k >= 2 && k <= N + 1));
            if (k >= 2 && k <= N + 1) begin
                chk({name, ".d1_num"}, int'(cmp_d1_num), k - 2);
                chk({name, ".d1"}, int'(cmp_d1), int'(mem[k-2]));
            end else begin
                chk({name, ".d1_idle"}, int'(cmp_d1), 0);
            end
            if (k == 2) begin
                chk({name, ".seed_d2"}, int'(cmp_d2), int'(mem[0]));
                chk({name, ".seed_d2_num"}, int'(cmp_d2_num), 0);
            end
            chk({name, ".busy"}, int'(busy), int'(k <= N + 2));
            chk({name, ".done"}, int'(done), int'(k == N + 3));
            if (k == N + 3) begin
                chk({name, ".result_num"}, int'(result_num), exp_num);
                chk({name, ".result_val"}, int'(result_val), exp_val);
                $display("scan %s: done cycle %0d result_num=%0d result_val=%0d",
                         name, k, result_num, result_val);
            end
            case (mode)
                1:       start = (k < N + 2);
                2:       start = (k == 5);
                default: start = 1'b0;
            endcase
            if (chain && k == N + 3) start = 1'b1;
        end
    endtask

    initial begin
        mem1 = 17;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.rd_en", int'(rd_en), 0);
        chk("reset.result_num", int'(result_num), 0);
        chk("reset.result_val", int'(result_val), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        load('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        scan("ascending", 0, 1'b0, 1'b0, 9, 10);
        load('{-50, -3, -7, -100, -20, -8, -60, -4, -90, -11});
        scan("negative", 0, 1'b0, 1'b0, 1, -3);
        load('{5, 10, 42, 3, 0, -1, 7, 42, 1, 2});
        scan("tie", 0, 1'b0, 1'b0, 2, 42);
        load('{7, 7, 7, 7, 7, 7, 7, 7, 7, 7});
        scan("all_equal", 0, 1'b0, 1'b0, 0, 7);
        load('{10, 9, 8, 7, 6, 5, 4, 3, 2, 1});
        scan("start_held", 1, 1'b0, 1'b0, 0, 10);
        load('{1, 2, 3, 4, 5, 6, 7, 8, 11, 9});
        scan("repulse", 2, 1'b1, 1'b0, 8, 11);
        // start is high in the done cycle; swap buffer contents before the next read
        load('{3, 1, 4, 1, 5, 9, 2, 6, 5, 3});
        scan("back_to_back", 0, 1'b0, 1'b1, 5, 9);

        // Abort mid-scan with reset in cycle 6
        load('{1, 2, 3, 4, 5, 6, 7, 8, 9, 120});
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("abort.done", int'(done), 0);
        end
        rst_n = 1'b0;
        #1;
        chk("abort.busy", int'(busy), 0);
        chk("abort.rd_en", int'(rd_en), 0);
        chk("abort.rd_addr", int'(rd_addr), 0);
        chk("abort.cmp_load", int'(cmp_load), 0);
        chk("abort.cmp_d1", int'(cmp_d1), 0);
        chk("abort.cmp_d2", int'(cmp_d2), 0);
        chk("abort.result_num", int'(result_num), 0);
        chk("abort.result_val", int'(result_val), 0);
        $display("abort: reset applied in cycle 6, outputs cleared");
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort.no_done", int'(done), 0);
        end
        load('{-5, 20, 3, 60, 99, 1, 0, 98, 12, -9});
        scan("after_abort", 0, 1'b0, 1'b0, 4, 99);

        // N_CLASS=1 instance
        start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            chk("n1.rd_en", int'(rd_en1), int'(k == 1));
            chk("n1.cmp_load", int'(cmp_load1), int'(k == 2));
            if (k == 2) begin
                chk("n1.d1", int'(cmp_d11), 17);
                chk("n1.d2", int'(cmp_d21), 17);
            end
            chk("n1.done", int'(done1), int'(k == 4));
            if (k == 4) begin
                chk("n1.result_num", int'(result_num1), 0);
                chk("n1.result_val", int'(result_val1), 17);
                $display("scan n1: done cycle %0d result_num=%0d result_val=%0d",
                         k, result_num1, result_val1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
